// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the multi-channel PWM slice.
// Counting-mode encoding and the centre-aligned direction state.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, period counter and direction FSM.
// Exposes the counter next-state so comparators align with cnt.
import pwm_pkg::*;

module pwm_timebase #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic [WIDTH-1:0]   period,
  output logic [WIDTH-1:0]   cnt,
  output logic [WIDTH-1:0]   cnt_nxt,
  output logic               boundary
);

  logic [PRESC_W-1:0] psc;
  logic [PRESC_W-1:0] psc_nxt;
  dir_t               dir;
  dir_t               dir_nxt;
  logic               tick;

  assign tick = en && (psc == presc);

  always_comb begin
    psc_nxt  = psc;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    boundary = 1'b0;
    if (!en) begin
      psc_nxt = '0;
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (!tick) begin
      psc_nxt = psc + 1'b1;
    end else begin
      psc_nxt = '0;
      if (mode == MODE_EDGE) begin
        dir_nxt = DIR_UP;
        if (cnt == period) begin
          boundary = 1'b1;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (period == '0) begin
        // degenerate triangle: every tick closes a period
        boundary = 1'b1;
        cnt_nxt  = '0;
        dir_nxt  = DIR_UP;
      end else if (dir == DIR_UP) begin
        if (cnt == period) begin
          dir_nxt = DIR_DOWN;
          cnt_nxt = cnt - 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (cnt == '0) begin
          boundary = 1'b1;
          dir_nxt  = DIR_UP;
          cnt_nxt  = WIDTH'(1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      psc <= psc_nxt;
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS PWM outputs on one shared timebase.
// Double-buffered config takes effect at period boundaries.
import pwm_pkg::*;

module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      mode,
  input  logic [PRESC_W-1:0]        presc,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [WIDTH-1:0]          cnt,
  output logic                      period_end,
  output logic                      load_ack
);

  localparam int DW = CHANNELS * WIDTH;

  logic               mode_act;
  logic [PRESC_W-1:0] presc_act;
  logic [WIDTH-1:0]   period_act;
  logic [DW-1:0]      duty_act;

  logic               mode_pnd;
  logic [PRESC_W-1:0] presc_pnd;
  logic [WIDTH-1:0]   period_pnd;
  logic [DW-1:0]      duty_pnd;
  logic               pend;

  logic               boundary;
  logic               apply;
  logic [WIDTH-1:0]   cnt_nxt;
  logic [DW-1:0]      duty_nxt;
  logic [CHANNELS-1:0] cmp;

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) u_tb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode_act),
    .presc    (presc_act),
    .period   (period_act),
    .cnt      (cnt),
    .cnt_nxt  (cnt_nxt),
    .boundary (boundary)
  );

  // a load coinciding with the boundary writes straight through
  assign apply = (!en && load) || (boundary && (pend || load));

  always_comb begin
    duty_nxt = duty_act;
    if (apply) begin
      duty_nxt = load ? duty_in : duty_pnd;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
    assign cmp[g] = en && (cnt_nxt < duty_nxt[g*WIDTH +: WIDTH]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act   <= MODE_EDGE;
      presc_act  <= '0;
      period_act <= '1;
      duty_act   <= '0;
      mode_pnd   <= MODE_EDGE;
      presc_pnd  <= '0;
      period_pnd <= '0;
      duty_pnd   <= '0;
      pend       <= 1'b0;
      pwm_out    <= '0;
    end else begin
      if (load) begin
        mode_pnd   <= mode;
        presc_pnd  <= presc;
        period_pnd <= period;
        duty_pnd   <= duty_in;
      end
      if (apply) begin
        mode_act   <= load ? mode : mode_pnd;
        presc_act  <= load ? presc : presc_pnd;
        period_act <= load ? period : period_pnd;
        duty_act   <= duty_nxt;
      end
      if (apply) begin
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
      pwm_out <= cmp;
    end
  end

  assign period_end = rst_n && boundary;
  assign load_ack   = rst_n && apply;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table vectors, corner sequences and random stimulus
// checked cycle by cycle against a phase-based reference model.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic          load = 1'b0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  period = '0;
  logic [CH*W-1:0] duty_in = '0;
  logic [CH-1:0] pwm_out;
  logic [W-1:0]  cnt;
  logic          period_end;
  logic          load_ack;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .presc      (presc),
    .period     (period),
    .duty_in    (duty_in),
    .load       (load),
    .pwm_out    (pwm_out),
    .cnt        (cnt),
    .period_end (period_end),
    .load_ack   (load_ack)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // reference model: position within the period, not a direction FSM
  int m_psc, m_pos, m_mode, m_presc, m_per;
  bit m_fresh, m_pend;
  int m_duty[CH];
  int p_mode, p_presc, p_per;
  int p_duty[CH];
  logic [CH-1:0] m_pwm;

  function automatic int m_cnt();
    if (m_mode == 0) return m_pos;
    return (m_pos <= m_per) ? m_pos : 2 * m_per - m_pos;
  endfunction

  function automatic bit m_bnd(bit e);
    if (!(e && m_psc == m_presc)) return 1'b0;
    if (m_mode == 0) return m_pos == m_per;
    return (m_per == 0) || (m_pos == 0 && !m_fresh);
  endfunction

  function automatic bit m_apply(bit e, bit ld);
    return (!e && ld) || (m_bnd(e) && (m_pend || ld));
  endfunction

  function automatic void m_reset();
    m_psc = 0; m_pos = 0; m_fresh = 1'b1; m_pend = 1'b0;
    m_mode = 0; m_presc = 0; m_per = (1 << W) - 1;
    p_mode = 0; p_presc = 0; p_per = 0;
    for (int i = 0; i < CH; i++) begin
      m_duty[i] = 0;
      p_duty[i] = 0;
    end
    m_pwm = '0;
  endfunction

  function automatic void m_step(bit e, bit ld);
    bit tick = e && (m_psc == m_presc);
    bit b = m_bnd(e);
    bit ap = m_apply(e, ld);
    if (!e) begin
      m_psc = 0; m_pos = 0; m_fresh = 1'b1;
    end else if (!tick) begin
      m_psc++;
    end else begin
      m_psc = 0;
      if (m_mode == 0) m_pos = b ? 0 : m_pos + 1;
      else if (m_per == 0) begin m_pos = 0; m_fresh = 1'b1; end
      else if (b) begin m_pos = 1; m_fresh = 1'b0; end
      else begin m_pos = (m_pos + 1) % (2 * m_per); m_fresh = 1'b0; end
    end
    if (ap && ld) begin
      m_mode = int'(mode); m_presc = int'(presc); m_per = int'(period);
      for (int i = 0; i < CH; i++) m_duty[i] = int'(duty_in[i*W +: W]);
    end else if (ap) begin
      m_mode = p_mode; m_presc = p_presc; m_per = p_per;
      for (int i = 0; i < CH; i++) m_duty[i] = p_duty[i];
    end
    if (ld) begin
      p_mode = int'(mode); p_presc = int'(presc); p_per = int'(period);
      for (int i = 0; i < CH; i++) p_duty[i] = int'(duty_in[i*W +: W]);
    end
    if (ap) m_pend = 1'b0;
    else if (ld) m_pend = 1'b1;
    for (int i = 0; i < CH; i++) m_pwm[i] = e && (m_cnt() < m_duty[i]);
  endfunction

  logic pe_s, la_s;
  logic [CH-1:0] pwm_s;
  int hi_g[CH];
  int len_g;

  task automatic cyc(input bit e, input bit ld);
    @(negedge clk);
    en = e;
    load = ld;
    #1;
    chk("cnt", int'(cnt), m_cnt());
    chk("pwm_out", int'(pwm_out), int'(m_pwm));
    chk("period_end", int'(period_end), int'(m_bnd(e)));
    chk("load_ack", int'(load_ack), int'(m_apply(e, ld)));
    pe_s = period_end;
    la_s = load_ack;
    pwm_s = pwm_out;
    @(posedge clk);
    m_step(e, ld);
  endtask

  // skip boundaries, then count one full period up to the next boundary
  task automatic measure(input int skip);
    int seen = 0;
    int budget = 3000;
    while (seen < skip && budget > 0) begin
      cyc(1'b1, 1'b0);
      budget--;
      if (pe_s) seen++;
    end
    len_g = 0;
    for (int i = 0; i < CH; i++) hi_g[i] = 0;
    do begin
      cyc(1'b1, 1'b0);
      budget--;
      len_g++;
      for (int i = 0; i < CH; i++) hi_g[i] += int'(pwm_s[i]);
    end while (!pe_s && budget > 0);
    if (!pe_s) chk("boundary timeout", int'(pe_s), 1);
  endtask

  typedef struct {
    logic mode;
    int   presc;
    int   period;
    int   duty[CH];
    int   plen;
    int   hi[CH];
  } vec_t;

  vec_t vecs[5];

  task automatic set_cfg(input logic md, input int ps, input int per,
                         input int d0, input int d1, input int d2, input int d3);
    mode = md;
    presc = PW'(ps);
    period = W'(per);
    duty_in = {W'(d3), W'(d2), W'(d1), W'(d0)};
  endtask

  initial begin
    int n;
    int hi_cnt;
    vecs[0] = '{1'b0, 0, 255, '{25, 50, 100, 200}, 256, '{25, 50, 100, 200}};
    vecs[1] = '{1'b1, 0, 9,   '{3, 0, 9, 10},       18,  '{5, 0, 17, 18}};
    vecs[2] = '{1'b0, 3, 4,   '{2, 0, 5, 4},        20,  '{8, 0, 20, 16}};
    vecs[3] = '{1'b0, 0, 99,  '{0, 150, 99, 1},     100, '{0, 100, 99, 1}};
    vecs[4] = '{1'b1, 1, 3,   '{1, 2, 3, 4},        12,  '{2, 6, 10, 12}};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset cnt", int'(cnt), 0);
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset period_end", int'(period_end), 0);
    chk("reset load_ack", int'(load_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      set_cfg(vecs[v].mode, vecs[v].presc, vecs[v].period,
              vecs[v].duty[0], vecs[v].duty[1], vecs[v].duty[2], vecs[v].duty[3]);
      cyc(1'b0, 1'b1);
      measure(1);
      chk($sformatf("v%0d period len", v), len_g, vecs[v].plen);
      for (int i = 0; i < CH; i++)
        chk($sformatf("v%0d ch%0d high", v, i), hi_g[i], vecs[v].hi[i]);
    end

    // duty 25 -> 200 loaded mid-period at cnt 50
    set_cfg(1'b0, 0, 255, 25, 25, 25, 25);
    cyc(1'b0, 1'b1);
    n = 0;
    while (m_cnt() != 50 && n < 400) begin cyc(1'b1, 1'b0); n++; end
    set_cfg(1'b0, 0, 255, 200, 200, 200, 200);
    cyc(1'b1, 1'b1);
    chk("A ack at load", int'(la_s), 0);
    n = 0;
    do begin cyc(1'b1, 1'b0); n++; end while (!pe_s && n < 400);
    chk("A ack with period_end", int'({pe_s, la_s}), 3);
    measure(0);
    chk("A new high", hi_g[0], 200);
    chk("A len", len_g, 256);

    // load in the boundary cycle itself
    n = 0;
    while (!m_bnd(1'b1) && n < 400) begin cyc(1'b1, 1'b0); n++; end
    set_cfg(1'b0, 0, 255, 130, 140, 150, 160);
    cyc(1'b1, 1'b1);
    chk("B ack+period_end", int'({pe_s, la_s}), 3);
    measure(0);
    for (int i = 0; i < CH; i++)
      chk($sformatf("B ch%0d high", i), hi_g[i], 130 + 10 * i);

    // asynchronous reset at cnt 120
    n = 0;
    while (m_cnt() != 120 && n < 400) begin cyc(1'b1, 1'b0); n++; end
    @(negedge clk);
    chk("C pwm before reset", int'(pwm_out), 15);
    en = 1'b0;
    load = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("C cnt in reset", int'(cnt), 0);
    chk("C pwm in reset", int'(pwm_out), 0);
    chk("C period_end in reset", int'(period_end), 0);
    chk("C load_ack in reset", int'(load_ack), 0);
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, 1'b0);
      if (pwm_s != '0) hi_cnt++;
    end
    chk("C duty0 after reset", hi_cnt, 0);

    // random traffic; mode only changes while stopped
    for (int k = 0; k < 3000; k++) begin
      bit e, ld;
      e = ($urandom_range(0, 59) != 0);
      ld = ($urandom_range(0, 14) == 0);
      if (ld) begin
        period = W'($urandom_range(1, 12));
        presc = PW'($urandom_range(0, 2));
        for (int i = 0; i < CH; i++) duty_in[i*W +: W] = W'($urandom_range(0, 14));
        mode = e ? m_mode[0] : 1'($urandom_range(0, 1));
      end
      cyc(e, ld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
